// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//               Sits beside the EX-stage ALU, takes one operation per
//               accepted START and stalls the pipeline through BUSY while
//               the WIDTH-step sequence runs. A divisor of zero and signed
//               overflow return their architectural results directly, one
//               cycle after START.
// Ports       : CLK     - clock, rising edge
//               RESET   - asynchronous reset, active low
//               START   - launch request, honoured only while ACCEPT=1
//               OP      - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//               DATA1   - dividend (rs1)
//               DATA2   - divisor (rs2)
//               FLUSH   - synchronous abort back to idle
//               ACCEPT  - ready for a new operation (IDLE or DONE)
//               BUSY    - sequence in progress (CALC or FIXUP)
//               DONE    - one-cycle pulse, RESULT valid
//               RESULT  - quotient or remainder, held until next launch
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             FLUSH,
    output logic             ACCEPT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operation context captured at launch
    logic             rem_sel;     // 1: deliver remainder, 0: quotient
    logic             neg_quot;    // quotient needs sign correction
    logic             neg_rem;     // remainder needs sign correction
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;        // dividend shifts out, quotient shifts in
    logic [WIDTH:0]   rem;         // partial remainder, one guard bit
    logic [CNT_W-1:0] cnt;

    // Launch-time decode of the incoming operands
    logic             op_signed;
    logic             d1_neg;
    logic             d2_neg;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic             div_zero;
    logic             overflow;
    logic             launch;
    logic             last_step;

    assign op_signed = ~OP[0];
    assign d1_neg    = op_signed & DATA1[WIDTH-1];
    assign d2_neg    = op_signed & DATA2[WIDTH-1];
    assign abs1      = d1_neg ? (~DATA1 + 1'b1) : DATA1;
    assign abs2      = d2_neg ? (~DATA2 + 1'b1) : DATA2;
    assign div_zero  = (DATA2 == '0);
    assign overflow  = op_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // One restoring step. The guard bit of rem takes part in the trial
    // subtract, so a shifted remainder up to 2*divisor-1 is compared exactly
    // and the borrow lands in the extra top bit of the difference.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             restore;

    assign shifted = {rem, quot[WIDTH-1]};
    assign trial   = shifted - {2'b00, divisor};
    assign restore = trial[WIDTH+1];

    // Sign correction applied in FIXUP (two's complement, modulo 2^WIDTH)
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign quot_fix = neg_quot ? (~quot + 1'b1) : quot;
    assign rem_fix  = neg_rem  ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        ACCEPT    = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                ACCEPT = 1'b1;
                DONE   = (state == S_DONE);
                if (FLUSH) begin
                    state_nxt = S_IDLE;
                end else if (START) begin
                    launch    = 1'b1;
                    state_nxt = (div_zero || overflow) ? S_DONE : S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                BUSY = 1'b1;
                if (FLUSH) begin
                    state_nxt = S_IDLE;
                end else if (last_step) begin
                    state_nxt = S_FIXUP;
                end
            end
            S_FIXUP: begin
                BUSY      = 1'b1;
                state_nxt = FLUSH ? S_IDLE : S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rem_sel  <= 1'b0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
            RESULT   <= '0;
        end else if (launch) begin
            rem_sel  <= OP[1];
            neg_quot <= d1_neg ^ d2_neg;
            neg_rem  <= d1_neg;
            divisor  <= abs2;
            quot     <= abs1;
            rem      <= '0;
            cnt      <= '0;
            // Fast paths publish their architectural result immediately
            if (div_zero) begin
                RESULT <= OP[1] ? DATA1 : '1;
            end else if (overflow) begin
                RESULT <= OP[1] ? '0 : MIN_NEG;
            end
        end else if (state == S_CALC && !FLUSH) begin
            rem  <= restore ? shifted[WIDTH:0] : trial[WIDTH:0];
            quot <= {quot[WIDTH-2:0], ~restore};
            cnt  <= cnt + CNT_W'(1);
        end else if (state == S_FIXUP && !FLUSH) begin
            RESULT <= rem_sel ? rem_fix : quot_fix;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer. A reference model
//               built from the architectural division rules and a simple
//               cycle countdown predicts ACCEPT/BUSY/DONE/RESULT; a compare
//               process checks them every cycle, and directed operations
//               pin results, latencies and BUSY lengths to literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [1:0]   OP;
    logic [W-1:0] DATA1;
    logic [W-1:0] DATA2;
    logic         FLUSH;
    logic         ACCEPT;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .OP     (OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .ACCEPT (ACCEPT),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: RISC-V division semantics plus a cycle countdown
    // ------------------------------------------------------------------
    function automatic logic [31:0] pred_result(input logic [1:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0])
            return op[1] ? (a % b) : (a / b);
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Cycles spent busy: none on fast paths, WIDTH steps plus fixup otherwise
    function automatic int pred_busy(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return W + 1;
    endfunction

    int          busy_left = 0;
    logic [31:0] pend      = '0;
    logic [31:0] m_result  = '0;
    logic        m_done    = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_left <= 0;
            m_result  <= '0;
            m_done    <= 1'b0;
        end else if (FLUSH) begin
            busy_left <= 0;
            m_done    <= 1'b0;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            m_done    <= (busy_left == 1);
            if (busy_left == 1) m_result <= pend;
        end else begin
            m_done <= 1'b0;
            if (START) begin
                if (pred_busy(OP, DATA1, DATA2) == 0) begin
                    m_result <= pred_result(OP, DATA1, DATA2);
                    m_done   <= 1'b1;
                end else begin
                    busy_left <= pred_busy(OP, DATA1, DATA2);
                    pend      <= pred_result(OP, DATA1, DATA2);
                end
            end
        end
    end

    always @(negedge CLK) begin
        check("busy",   32'(BUSY),   32'(busy_left > 0));
        check("accept", 32'(ACCEPT), 32'(busy_left == 0));
        check("done",   32'(DONE),   32'(m_done));
        check("result", RESULT,      m_result);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Holds START for exactly one sampling edge from the current time
    task automatic drive_start(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        START = 1'b1;
        OP    = op;
        DATA1 = a;
        DATA2 = b;
        tick();
        START = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        tick();
        drive_start(op, a, b);
    endtask

    // Edge count (relative to the START sampling edge) at which DONE shows
    task automatic wait_done(input int edges_in, input int busy_in,
                             output int edges, output int busy_cnt);
        edges    = edges_in;
        busy_cnt = busy_in;
        while (DONE !== 1'b1 && edges < 40) begin
            busy_cnt += int'(BUSY);
            tick();
            edges++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_edges,
                       input int exp_busy);
        int edges;
        int busy_cnt;
        issue(op, a, b);
        wait_done(0, 0, edges, busy_cnt);
        check({name, " latency"}, 32'(edges), 32'(exp_edges));
        check({name, " busy"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, " result"}, RESULT, exp_r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int edges;
        int busy_cnt;
        int done_seen;

        RESET = 1'b0;
        START = 1'b0;
        FLUSH = 1'b0;
        OP    = 2'b00;
        DATA1 = '0;
        DATA2 = '0;
        repeat (3) tick();
        check("reset accept", 32'(ACCEPT), 32'd1);
        check("reset busy",   32'(BUSY),   32'd0);
        check("reset done",   32'(DONE),   32'd0);
        check("reset result", RESULT,      32'd0);
        RESET = 1'b1;
        tick();

        // Normal signed / unsigned operations
        run("DIV 7/-2",  OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 33);
        run("REM 7/-2",  OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         33, 33);
        run("REM -7/2",  OP_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 33);
        run("DIVU big/2", OP_DIVU, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF, 33, 33);

        // Divide by zero fast path
        run("DIV 5/0",   OP_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, 0, 0);
        run("REMU x/0",  OP_REMU, 32'h1234,       32'd0,         32'h1234,      0, 0);

        // Signed overflow fast path; unsigned forms run the full sequence.
        // 0x80000000 / 0xFFFFFFFF unsigned is 0; the reversed operands give 1.
        run("DIV ovf",   OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run("REM ovf",   OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0, 0);
        run("DIVU ovf",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, 33);
        run("DIVU rev",  OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0000, 32'd1,         33, 33);

        // Back-to-back with a START pulse ignored during CALC
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) tick();
        drive_start(OP_DIV, 32'd99, 32'd3);
        wait_done(6, 6, edges, busy_cnt);
        check("b2b first latency", 32'(edges), 32'd33);
        check("b2b first result",  RESULT,     32'd14);
        drive_start(OP_REMU, 32'd100, 32'd7);
        wait_done(0, 0, edges, busy_cnt);
        check("b2b second latency", 32'(edges),    32'd33);
        check("b2b second busy",    32'(busy_cnt), 32'd33);
        check("b2b second result",  RESULT,        32'd2);

        // FLUSH at counter 10 aborts without DONE and keeps RESULT
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (10) tick();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("flush busy",   32'(BUSY),   32'd0);
        check("flush accept", 32'(ACCEPT), 32'd1);
        check("flush done",   32'(DONE),   32'd0);
        check("flush result", RESULT,      32'd2);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (DONE === 1'b1) done_seen++;
        end
        check("flush no done", 32'(done_seen), 32'd0);

        // FLUSH beats a simultaneous START in IDLE
        FLUSH = 1'b1;
        START = 1'b1;
        OP    = OP_DIV;
        DATA1 = 32'd9;
        DATA2 = 32'd3;
        tick();
        FLUSH = 1'b0;
        START = 1'b0;
        check("flush+start busy",   32'(BUSY), 32'd0);
        check("flush+start done",   32'(DONE), 32'd0);
        check("flush+start result", RESULT,    32'd2);

        // Asynchronous reset mid-CALC, between edges
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (5) tick();
        #2;
        RESET = 1'b0;
        #1;
        check("async reset busy",   32'(BUSY),   32'd0);
        check("async reset done",   32'(DONE),   32'd0);
        check("async reset accept", 32'(ACCEPT), 32'd1);
        check("async reset result", RESULT,      32'd0);
        tick();
        tick();
        RESET = 1'b1;
        run("DIV 20/4", OP_DIV, 32'd20, 32'd4, 32'd5, 33, 33);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
